// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared sizing constants, word/pointer types and the
// pointer range check for the data memory.
package data_mem_pkg;

    localparam int WIDTH = 256;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    ptr_t;

    // True when the pointer addresses a physical entry (0..DEPTH-1).
    function automatic logic in_range(input ptr_t ptr);
        return (int'(ptr) < DEPTH);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x WIDTH storage with asynchronous clear, a single
// synchronous write port and a combinational read port. Out-of-range read
// addresses return zero; the write enable is qualified by the caller.
module data_mem_array
    import data_mem_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  we,
    input  ptr_t  waddr,
    input  word_t wdata,
    input  ptr_t  raddr,
    output word_t rdata
);

    word_t mem [DEPTH];

    // Storage: cleared while reset is high, full-word write otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_range(waddr)) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read; holes in the address space read as zero.
    always_comb begin
        rdata = '0;
        if (in_range(raddr)) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: six-entry, 256-bit word-addressed data memory with a
// registered read output.
// Strobe semantics: write_data and read_data are level-sampled on each rising
// clk; there is no handshake and every sampled strobe completes in that cycle.
// Optional feature macro: DATA_MEM_WRITE_THROUGH_EN -- when defined, a
// same-cycle write and read to the same in-range pointer returns the new
// word; otherwise the read returns the word held before the write.
module data_memory
    import data_mem_pkg::*;
(
    output word_t data,
    input  ptr_t  pointer,
    input  logic  write_data,
    input  logic  read_data,
    input  word_t data_to_write,
    input  logic  reset,
    input  logic  clk
);

    logic  ptr_ok;
    logic  mem_we;
    word_t mem_rdata;
    word_t read_word;

    assign ptr_ok = in_range(pointer);
    assign mem_we = write_data && ptr_ok;

    data_mem_array u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (pointer),
        .wdata (data_to_write),
        .raddr (pointer),
        .rdata (mem_rdata)
    );

    // Select the word a read strobe captures this cycle.
    always_comb begin
        read_word = '0;
        if (ptr_ok) begin
`ifdef DATA_MEM_WRITE_THROUGH_EN
            read_word = write_data ? data_to_write : mem_rdata;
`else
            // The array still holds the pre-write word during this cycle.
            read_word = mem_rdata;
`endif
        end
    end

    // Output register: cleared by reset, loaded only on a read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (read_data) begin
            data <= read_word;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory.
module tb_data_memory;
    import data_mem_pkg::*;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    ptr_t  pointer = '0;
    logic  write_data = 1'b0;
    logic  read_data = 1'b0;
    word_t data_to_write = '0;
    word_t data;

    word_t exp_q [$];
    word_t model [DEPTH];
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam word_t PAT_5 = {64{4'h5}};
    localparam word_t PAT_A = {64{4'hA}};

    data_memory dut (
        .data          (data),
        .pointer       (pointer),
        .write_data    (write_data),
        .read_data     (read_data),
        .data_to_write (data_to_write),
        .reset         (reset),
        .clk           (clk)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard: compare data against the oldest expected value.
    task automatic check_data(input string tag);
        word_t exp;
        exp = exp_q.pop_front();
        n_checks++;
        assert (data === exp) else begin
            n_fail++;
            $error("FAIL %s: data=%h expected=%h", tag, data, exp);
        end
    endtask

    function automatic word_t model_read(input int p);
        return (p < DEPTH) ? model[p] : '0;
    endfunction

    task automatic do_write(input int p, input word_t d);
        @(negedge clk);
        pointer       = ptr_t'(p);
        data_to_write = d;
        write_data    = 1'b1;
        @(posedge clk);
        #1;
        write_data = 1'b0;
        if (p < DEPTH) model[p] = d;
    endtask

    task automatic do_read(input int p, input string tag);
        @(negedge clk);
        pointer   = ptr_t'(p);
        read_data = 1'b1;
        @(posedge clk);
        #1;
        read_data = 1'b0;
        exp_q.push_back(model_read(p));
        check_data(tag);
    endtask

    task automatic do_write_read(input int p, input word_t d, input word_t exp, input string tag);
        @(negedge clk);
        pointer       = ptr_t'(p);
        data_to_write = d;
        write_data    = 1'b1;
        read_data     = 1'b1;
        @(posedge clk);
        #1;
        write_data = 1'b0;
        read_data  = 1'b0;
        if (p < DEPTH) model[p] = d;
        exp_q.push_back(exp);
        check_data(tag);
    endtask

    initial begin
        word_t w;
        word_t held;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset with no clock edge
        #1 reset = 1'b1;
        #1;
        exp_q.push_back('0);
        check_data("reset_immediate");
        for (int p = 0; p < DEPTH; p++) do_read(p, "read_during_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < DEPTH; p++) do_read(p, "read_after_reset");

        // Write/read each entry with both checkerboards
        for (int p = 0; p < DEPTH; p++) begin
            do_write(p, PAT_5);
            do_read(p, "rw_pat5");
            do_write(p, PAT_A);
            do_read(p, "rw_patA");
        end
        for (int p = 0; p < DEPTH; p++) do_read(p, "readback_all");

        // Walking byte at pointer 3
        for (int n = 0; n < 32; n++) begin
            w = word_t'(8'hAA) << (8 * n);
            do_write(3, w);
            do_read(3, "walking_byte");
        end
        for (int p = 0; p < DEPTH; p++) if (p != 3) do_read(p, "walk_others");

        // Out-of-range pointers
        do_write(6, 256'h1234);
        do_read(6, "oor_read6");
        do_read(7, "oor_read7");
        for (int p = 0; p < DEPTH; p++) do_read(p, "oor_unchanged");

        // Same-cycle write and read at pointer 2
        do_write(2, PAT_5);
`ifdef DATA_MEM_WRITE_THROUGH_EN
        do_write_read(2, PAT_A, PAT_A, "same_cycle_wt");
`else
        do_write_read(2, PAT_A, PAT_5, "same_cycle_old");
`endif
        do_read(2, "same_cycle_mem");

        // Hold for 10 cycles without strobes while the pointer moves
        held = PAT_A;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pointer = ptr_t'(c % 8);
            @(posedge clk);
            #1;
            exp_q.push_back(held);
            check_data("hold");
        end

        // Reset asserted mid-write
        @(negedge clk);
        pointer       = ptr_t'(1);
        data_to_write = 256'h1234;
        write_data    = 1'b1;
        #2 reset = 1'b1;
        #1;
        exp_q.push_back('0);
        check_data("mid_reset_data");
        @(posedge clk);
        #1;
        @(negedge clk);
        write_data = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        do_read(1, "mid_reset_dropped");
        do_read(2, "mid_reset_cleared");
        do_write(1, PAT_5);
        do_read(1, "post_reset_rw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
